// File: rtl/lvdc_pkg.sv
// Shared types for the LVDC serial transfer register family.
//   xfer_mode_t  : transfer mode carried on MODE and latched on START
//   xfer_state_t : control state of the transfer sequencer
//   parity_term  : the bit a shift contributes to the parity accumulator
package lvdc_pkg;

   typedef enum logic [1:0] {
      SHIFT_IN  = 2'b00,
      RECIRC    = 2'b01,
      SHIFT_OUT = 2'b10,
      EXCHANGE  = 2'b11
   } xfer_mode_t;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } xfer_state_t;

   // Modes that pull bits from SIN count the incoming bit; modes that
   // only move existing contents count the bit leaving through PQ[0].
   function automatic logic parity_term(input xfer_mode_t m, input logic sin, input logic q0);
      logic t;
      case (m)
         RECIRC, SHIFT_OUT: t = q0;
         default:           t = sin;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/lvdc_bit_counter.sv
// Up-counter used to sequence bit-serial transfers.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count one step
//   cnt      : current count
//   tc       : count has reached N
module lvdc_bit_counter #(
   parameter int CNT_W = 4,
   parameter int N     = 13
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             tc
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(N);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= cnt + 1'b1;
   end

   assign tc = (cnt == TERM);

endmodule

// File: rtl/lvdc_serial_xfer_reg.sv
// Parametrised serial/parallel transfer register. Shifts WIDTH bits LSB
// first on BT strobes, supports parallel load and four transfer modes,
// accumulates parity over the transferred bits and flags misuse.
//   CLK, RST : clock, asynchronous active-high reset
//   BT       : bit-time strobe (one shift per pulse while busy)
//   START    : begin a WIDTH-bit transfer, MODE sampled with it
//   SIN      : serial input
//   PLD, PD  : parallel load request and data (idle only)
//   CLR      : synchronous clear / abort
//   SOUT     : PQ[0]
//   PQ       : register contents
//   BUSY     : transfer in progress
//   DONE     : one-cycle pulse after the final shift
//   PAR      : parity of the last completed transfer
//   ERR      : sticky misuse flag (START/PLD while busy)
module lvdc_serial_xfer_reg
   import lvdc_pkg::*;
#(
   parameter int WIDTH      = 13,
   parameter bit PARITY_ODD = 1'b1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             BT,
   input  logic             START,
   input  logic [1:0]       MODE,
   input  logic             SIN,
   input  logic             PLD,
   input  logic [WIDTH-1:0] PD,
   input  logic             CLR,
   output logic             SOUT,
   output logic [WIDTH-1:0] PQ,
   output logic             BUSY,
   output logic             DONE,
   output logic             PAR,
   output logic             ERR
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   xfer_state_t      state_q, state_d;
   xfer_mode_t       mode_q;
   logic [WIDTH-1:0] pq_q;
   logic [CNT_W-1:0] cnt;
   logic             cnt_tc;
   logic             acc_q;
   logic             accept, shift_en, last_shift, misuse;
   logic             msb_in, pterm;

   lvdc_bit_counter #(.CNT_W(CNT_W), .N(WIDTH)) u_cnt (
      .clk (CLK),
      .rst (RST),
      .clr (accept | CLR),
      .en  (shift_en),
      .cnt (cnt),
      .tc  (cnt_tc)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      shift_en   = 1'b0;
      last_shift = 1'b0;
      misuse     = 1'b0;
      case (state_q)
         IDLE: begin
            // BT in the accepting cycle is dropped; first shift is next BT.
            if (START) begin
               accept  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            misuse = START | PLD;
            // tc guard keeps a stray count from ever shifting past WIDTH.
            if (BT && !cnt_tc) begin
               shift_en = 1'b1;
               if (cnt == LAST) begin
                  last_shift = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (CLR) begin
         state_d    = IDLE;
         accept     = 1'b0;
         shift_en   = 1'b0;
         last_shift = 1'b0;
         misuse     = 1'b0;
      end
   end

   always_comb begin
      msb_in = SIN;
      case (mode_q)
         RECIRC:    msb_in = pq_q[0];
         SHIFT_OUT: msb_in = 1'b0;
         default:   msb_in = SIN;
      endcase
      pterm = parity_term(mode_q, SIN, pq_q[0]);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pq_q   <= '0;
         mode_q <= SHIFT_IN;
         acc_q  <= 1'b0;
         PAR    <= 1'b0;
         DONE   <= 1'b0;
         ERR    <= 1'b0;
      end else begin
         DONE <= last_shift;
         if (CLR) begin
            pq_q <= '0;
            ERR  <= 1'b0;
         end else begin
            // Load lands on the same edge as START, so shifting uses PD.
            if (state_q == IDLE && PLD) pq_q <= PD;
            if (accept) begin
               mode_q <= xfer_mode_t'(MODE);
               acc_q  <= PARITY_ODD;
            end
            if (misuse) ERR <= 1'b1;
            if (shift_en) begin
               pq_q  <= {msb_in, pq_q[WIDTH-1:1]};
               acc_q <= acc_q ^ pterm;
            end
            if (last_shift) PAR <= acc_q ^ pterm;
         end
      end
   end

   assign PQ   = pq_q;
   assign SOUT = pq_q[0];
   assign BUSY = (state_q == SHIFT);

endmodule

// File: tb/tb_lvdc_serial_xfer_reg.sv
// Directed bench for lvdc_serial_xfer_reg at WIDTH=13, PARITY_ODD=1.
module tb_lvdc_serial_xfer_reg;

   localparam int W = 13;

   logic         CLK = 1'b0;
   logic         RST, BT, START, SIN, PLD, CLR;
   logic [1:0]   MODE;
   logic [W-1:0] PD;
   logic         SOUT, BUSY, DONE, PAR, ERR;
   logic [W-1:0] PQ;

   int n_cmp = 0;
   int n_bad = 0;
   int done_total = 0;
   int done_base;

   lvdc_serial_xfer_reg #(.WIDTH(W), .PARITY_ODD(1'b1)) dut (
      .CLK(CLK), .RST(RST), .BT(BT), .START(START), .MODE(MODE), .SIN(SIN),
      .PLD(PLD), .PD(PD), .CLR(CLR), .SOUT(SOUT), .PQ(PQ), .BUSY(BUSY),
      .DONE(DONE), .PAR(PAR), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) if (DONE) done_total <= done_total + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic pulse_bt();
      BT = 1'b1;
      cyc(1);
      BT = 1'b0;
   endtask

   logic [W-1:0] vec, seq;

   initial begin
      RST = 1'b1; BT = 0; START = 0; SIN = 0; PLD = 0; CLR = 0; MODE = 2'b00; PD = '0;
      cyc(2);
      RST = 1'b0;
      cyc(1);
      chk("rst_pq",   32'(PQ),   32'h0);
      chk("rst_busy", 32'(BUSY), 32'h0);
      chk("rst_done", 32'(DONE), 32'h0);
      chk("rst_par",  32'(PAR),  32'h0);
      chk("rst_err",  32'(ERR),  32'h0);
      chk("rst_sout", 32'(SOUT), 32'h0);

      // 1: reset mid-transfer
      done_base = done_total;
      PD = 13'h1555; PLD = 1; START = 1; MODE = 2'b00; SIN = 1;
      cyc(1);
      PLD = 0; START = 0;
      repeat (6) pulse_bt();
      PLD = 1; cyc(1); PLD = 0;
      chk("t1_err_set", 32'(ERR), 32'h1);
      RST = 1'b1; #1;
      chk("t1_pq",   32'(PQ),   32'h0);
      chk("t1_busy", 32'(BUSY), 32'h0);
      chk("t1_err",  32'(ERR),  32'h0);
      chk("t1_par",  32'(PAR),  32'h0);
      @(posedge CLK); #1;
      RST = 1'b0;
      cyc(3);
      chk("t1_nodone", 32'(done_total - done_base), 32'h0);

      // 2: SHIFT_OUT of 1555, BTs 3 cycles apart
      done_base = done_total;
      PD = 13'h1555; PLD = 1; cyc(1); PLD = 0;
      START = 1; MODE = 2'b10; cyc(1); START = 0;
      chk("t2_busy", 32'(BUSY), 32'h1);
      seq = '0;
      for (int i = 0; i < W; i++) begin
         seq[i] = SOUT;
         pulse_bt();
         if (i != W - 1) cyc(2);
      end
      chk("t2_sout_seq", 32'(seq), 32'h1555);
      chk("t2_done", 32'(DONE), 32'h1);
      chk("t2_pq",   32'(PQ),   32'h0);
      chk("t2_par",  32'(PAR),  32'h0);
      chk("t2_busy_end", 32'(BUSY), 32'h0);
      cyc(1);
      chk("t2_done_low", 32'(DONE), 32'h0);
      chk("t2_done_cnt", 32'(done_total - done_base), 32'h1);

      // 3: SHIFT_IN of 0F0F
      vec = 13'h0F0F;
      START = 1; MODE = 2'b00; cyc(1); START = 0;
      for (int i = 0; i < W; i++) begin
         SIN = vec[i];
         pulse_bt();
      end
      SIN = 0;
      chk("t3_pq",   32'(PQ),   32'h0F0F);
      chk("t3_par",  32'(PAR),  32'h1);
      chk("t3_done", 32'(DONE), 32'h1);
      cyc(1);
      chk("t3_busy", 32'(BUSY), 32'h0);

      // 4: RECIRC of 1234 (5 ones -> PAR 0)
      done_base = done_total;
      PD = 13'h1234; PLD = 1; START = 1; MODE = 2'b01; cyc(1); PLD = 0; START = 0;
      repeat (5) pulse_bt();
      chk("t4_rot5", 32'(PQ), 32'h1491);
      chk("t4_busy", 32'(BUSY), 32'h1);
      repeat (8) pulse_bt();
      chk("t4_pq", 32'(PQ), 32'h1234);
      chk("t4_par", 32'(PAR), 32'h0);
      cyc(2);
      chk("t4_done_cnt", 32'(done_total - done_base), 32'h1);

      // 5: misuse during SHIFT_OUT of 00A5, then CLR
      done_base = done_total;
      PD = 13'h00A5; PLD = 1; START = 1; MODE = 2'b10; cyc(1); PLD = 0; START = 0;
      repeat (3) pulse_bt();
      PD = 13'h1FFF; PLD = 1; START = 1; MODE = 2'b01; cyc(1); PLD = 0; START = 0;
      chk("t5_err",  32'(ERR),  32'h1);
      chk("t5_busy", 32'(BUSY), 32'h1);
      chk("t5_pq",   32'(PQ),   32'h0014);
      repeat (10) pulse_bt();
      chk("t5_pq_end", 32'(PQ),  32'h0);
      chk("t5_par",    32'(PAR), 32'h1);
      chk("t5_err_sticky", 32'(ERR), 32'h1);
      cyc(1);
      chk("t5_done_cnt", 32'(done_total - done_base), 32'h1);
      PD = 13'h0F00; PLD = 1; cyc(1); PLD = 0;
      CLR = 1; cyc(1); CLR = 0;
      chk("t5_clr_err", 32'(ERR), 32'h0);
      chk("t5_clr_pq",  32'(PQ),  32'h0);
      chk("t5_clr_par", 32'(PAR), 32'h1);

      // 5b: CLR aborts a transfer without DONE
      done_base = done_total;
      START = 1; MODE = 2'b00; SIN = 1; cyc(1); START = 0;
      repeat (4) pulse_bt();
      CLR = 1; cyc(1); CLR = 0;
      chk("t5b_busy", 32'(BUSY), 32'h0);
      chk("t5b_pq",   32'(PQ),   32'h0);
      repeat (W) pulse_bt();
      cyc(1);
      chk("t5b_nodone", 32'(done_total - done_base), 32'h0);
      chk("t5b_pq_idle", 32'(PQ), 32'h0);

      // 6: START with BT, then START on the DONE cycle
      done_base = done_total;
      START = 1; BT = 1; MODE = 2'b00; SIN = 1; cyc(1); START = 0; BT = 0;
      chk("t6_noshift", 32'(PQ),   32'h0);
      chk("t6_busy",    32'(BUSY), 32'h1);
      repeat (W - 1) pulse_bt();
      chk("t6_still_busy", 32'(BUSY), 32'h1);
      chk("t6_no_early_done", 32'(DONE), 32'h0);
      pulse_bt();
      chk("t6_pq",   32'(PQ),   32'h1FFF);
      chk("t6_done", 32'(DONE), 32'h1);
      chk("t6_busy_gap", 32'(BUSY), 32'h0);
      START = 1; MODE = 2'b01; cyc(1); START = 0; SIN = 0;
      chk("t6_b2b_busy", 32'(BUSY), 32'h1);
      chk("t6_b2b_done", 32'(DONE), 32'h0);
      repeat (W) pulse_bt();
      chk("t6_b2b_pq",  32'(PQ),  32'h1FFF);
      chk("t6_b2b_par", 32'(PAR), 32'h0);
      cyc(1);
      chk("t6_done_cnt", 32'(done_total - done_base), 32'h2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
